// File: rtl/lfsr_hex_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_pkg
// Purpose  : Shared constants for the LFSR hex generator.
//            - c_seg_table    : active-low 7-segment patterns for 0..F,
//                               bit order g..a (bit 6 = g).
//            - c_default_taps : default feedback mask (x^8+x^4+x^3+x^2+1).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package lfsr_pkg;

  // Default feedback mask. This polynomial is primitive, which gives a
  // maximal-length 255-state sequence at WIDTH = 8.
  localparam logic [31:0] c_default_taps = 32'h0000_001D;

  // Index 0 is the rightmost entry; the list runs from F down to 0.
  localparam logic [15:0][6:0] c_seg_table = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage
`default_nettype wire

// File: rtl/lfsr_hex_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_hex_gen_if
// Purpose  : Control / observation bundle for lfsr_hex_gen.
// Signals  : load, seed[WIDTH], step, run      (master -> slave)
//            state[WIDTH], hex[7*NDIG], wrap,
//            period[WIDTH]                     (slave -> master)
// Modports : master (controller / testbench side), slave (generator side)
// Revision : 1.0 - initial release
// ============================================================================
interface lfsr_hex_gen_if #(
  parameter int WIDTH = 8
);
  localparam int NDIG = WIDTH / 4;

  logic                  load;
  logic [WIDTH-1:0]      seed;
  logic                  step;
  logic                  run;
  logic [WIDTH-1:0]      state;
  logic [7*NDIG-1:0]     hex;
  logic                  wrap;
  logic [WIDTH-1:0]      period;

  modport master (
    output load, seed, step, run,
    input  state, hex, wrap, period
  );

  modport slave (
    input  load, seed, step, run,
    output state, hex, wrap, period
  );

endinterface
`default_nettype wire

// File: rtl/lfsr_hex_gen_hex7seg.sv
`default_nettype none
// ============================================================================
// Module   : hex7seg
// Purpose  : Combinational hex-digit to active-low 7-segment decoder.
// Ports    : nibble [3:0] in  - hex digit value
//            seg    [6:0] out - segments g..a, active low
// Revision : 1.0 - initial release
// ============================================================================
module hex7seg
  import lfsr_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = c_seg_table[nibble];

endmodule
`default_nettype wire

// File: rtl/lfsr_hex_gen.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_hex_gen
// Purpose  : Fibonacci LFSR with seed load, single-step and prescaled
//            auto-run. It detects the return to the loaded seed and shows
//            the state on registered active-low 7-segment digits.
// Ports    : clk        in  - single clock, rising edge
//            reset      in  - asynchronous, active-high
//            bus.load   in  - load seed (priority over advance)
//            bus.seed   in  - seed value (0 is replaced by 1)
//            bus.step   in  - one advance per cycle held high
//            bus.run    in  - advance once every DIV cycles
//            bus.state  out - current LFSR register
//            bus.hex    out - registered 7-seg digits, digit k = state nibble k
//            bus.wrap   out - one-cycle pulse on return to the seed
//            bus.period out - step count of the last completed cycle
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_hex_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = c_default_taps[WIDTH-1:0],
  parameter int               DIV   = 4
)(
  input  logic           clk,
  input  logic           reset,
  lfsr_hex_gen_if.slave  bus
);

  localparam int NDIG = WIDTH / 4;
  // A prescaler of at least one bit keeps DIV = 1 legal. With DIV = 1 the
  // count stays at 0, so a tick occurs every cycle.
  localparam int              PW          = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]   c_pre_last  = PW'(DIV - 1);
  localparam logic [WIDTH-1:0] c_one      = WIDTH'(1);

  logic [PW-1:0]     r_pre;
  logic [WIDTH-1:0]  r_state;
  logic [WIDTH-1:0]  r_seed_cmp;
  logic [WIDTH-1:0]  r_step_cnt;
  logic [WIDTH-1:0]  r_period;
  logic              r_wrap;

  logic              w_tick;
  logic              w_advance;
  logic              w_feedback;
  logic [WIDTH-1:0]  w_next;
  logic [WIDTH-1:0]  w_load_val;
  logic [WIDTH-1:0]  w_cnt_inc;
  logic [7*NDIG-1:0] w_seg;

  // --------------------------------------------------------------------------
  // Prescaler. It is held at 0 while run is low, so a run session always
  // waits a full DIV period before its first advance.
  // --------------------------------------------------------------------------
  assign w_tick = bus.run && (r_pre == c_pre_last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pre <= '0;
    end else if (bus.load || !bus.run || w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + PW'(1);
    end
  end

  // --------------------------------------------------------------------------
  // LFSR core
  // --------------------------------------------------------------------------
  // The OR merges a coincident step and tick into a single advance.
  assign w_advance  = bus.step || w_tick;
  assign w_feedback = ^(r_state & TAPS);
  // An all-zero state cannot leave itself through XOR feedback, so it is
  // forced to 1 instead.
  assign w_next     = (r_state == '0) ? c_one : {w_feedback, r_state[WIDTH-1:1]};
  assign w_load_val = (bus.seed == '0) ? c_one : bus.seed;
  // The increment saturates, so period reports all-ones instead of a small
  // wrapped value.
  assign w_cnt_inc  = (r_step_cnt == '1) ? r_step_cnt : r_step_cnt + c_one;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= c_one;
      r_seed_cmp <= c_one;
      r_step_cnt <= '0;
      r_period   <= '0;
      r_wrap     <= 1'b0;
    end else if (bus.load) begin
      r_state    <= w_load_val;
      r_seed_cmp <= w_load_val;
      r_step_cnt <= '0;
      r_wrap     <= 1'b0;
    end else if (w_advance) begin
      r_state <= w_next;
      if (w_next == r_seed_cmp) begin
        r_wrap     <= 1'b1;
        r_period   <= w_cnt_inc;
        r_step_cnt <= '0;
      end else begin
        r_wrap     <= 1'b0;
        r_step_cnt <= w_cnt_inc;
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Digit decode and output registers. The reset pattern matches the
  // decoded reset state (value 1).
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < NDIG; k++) begin : g_digit
    localparam logic [6:0] c_digit_rst = (k == 0) ? c_seg_table[1] : c_seg_table[0];
    logic [6:0] r_digit;

    hex7seg u_dec (
      .nibble (r_state[4*k +: 4]),
      .seg    (w_seg[7*k +: 7])
    );

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_digit <= c_digit_rst;
      end else begin
        r_digit <= w_seg[7*k +: 7];
      end
    end

    assign bus.hex[7*k +: 7] = r_digit;
  end

  assign bus.state  = r_state;
  assign bus.wrap   = r_wrap;
  assign bus.period = r_period;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_hex_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_lfsr_hex_gen
// Purpose  : Self-checking bench for lfsr_hex_gen (WIDTH=8, TAPS=0x1D, DIV=4).
//            A sequence-level reference model is compared with the DUT on
//            every falling edge. Hand-computed literals pin key points.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lfsr_hex_gen;

  localparam int         W    = 8;
  localparam int         DIV  = 4;
  localparam logic [7:0] TAPS = 8'h1D;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lfsr_hex_gen_if #(.WIDTH(W)) bus ();

  lfsr_hex_gen #(.WIDTH(W), .TAPS(TAPS), .DIV(DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference digit shapes, active low, bit order g..a.
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [13:0] hex_of(input logic [7:0] s);
    return {seg_of(s[7:4]), seg_of(s[3:0])};
  endfunction

  // Next state: parity of tapped bits shifted in at the top, zero escapes to 1.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    int par;
    if (s == 8'h00) return 8'h01;
    par = $countones(s & TAPS) % 2;
    return 8'((par << 7) | (s >> 1));
  endfunction

  // ---------------- reference model ----------------
  logic [7:0]  m_state, m_seed, m_period;
  logic [13:0] m_hex;
  logic        m_wrap;
  int          m_cnt, m_runlen;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_state  <= 8'h01;
      m_seed   <= 8'h01;
      m_period <= 8'h00;
      m_cnt    <= 0;
      m_runlen <= 0;
      m_wrap   <= 1'b0;
      m_hex    <= hex_of(8'h01);
    end else begin
      m_hex    <= hex_of(m_state);
      m_runlen <= (bus.run && !bus.load) ? m_runlen + 1 : 0;
      if (bus.load) begin
        m_state <= (bus.seed == 8'h00) ? 8'h01 : bus.seed;
        m_seed  <= (bus.seed == 8'h00) ? 8'h01 : bus.seed;
        m_cnt   <= 0;
        m_wrap  <= 1'b0;
      end else if (bus.step || (bus.run && (m_runlen % DIV == DIV - 1))) begin
        m_state <= lfsr_next(m_state);
        if (lfsr_next(m_state) == m_seed) begin
          m_wrap   <= 1'b1;
          m_period <= 8'((m_cnt + 1 > 255) ? 255 : m_cnt + 1);
          m_cnt    <= 0;
        end else begin
          m_wrap <= 1'b0;
          m_cnt  <= (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
        end
      end else begin
        m_wrap <= 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("model_state",  bus.state,  m_state);
    chk("model_hex",    bus.hex,    m_hex);
    chk("model_wrap",   bus.wrap,   m_wrap);
    chk("model_period", bus.period, m_period);
  end

  task automatic apply(input logic l, input logic [7:0] s, input logic st, input logic r);
    bus.load = l;
    bus.seed = s;
    bus.step = st;
    bus.run  = r;
    @(negedge clk);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int k;
    bus.load = 1'b0; bus.seed = 8'h00; bus.step = 1'b0; bus.run = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_state",  bus.state,  8'h01);
    chk("rst_hex",    bus.hex,    14'b1000000_1111001);
    chk("rst_wrap",   bus.wrap,   1'b0);
    chk("rst_period", bus.period, 8'h00);
    reset = 1'b0;

    apply(0, 8'h00, 1, 0);  chk("step_80", bus.state, 8'h80);
    apply(0, 8'h00, 0, 0);  chk("hex_80",  bus.hex,   14'b0000000_1000000);
    apply(0, 8'h00, 1, 0);  chk("step_40", bus.state, 8'h40);
    apply(0, 8'h00, 1, 0);  chk("step_20", bus.state, 8'h20);

    apply(1, 8'h00, 0, 0);  chk("load_zero", bus.state, 8'h01);
    apply(1, 8'hA5, 0, 0);  chk("load_a5",   bus.state, 8'hA5);
    apply(0, 8'h00, 0, 0);  chk("hex_a5",    bus.hex,   14'b0001000_0010010);

    // Prescaler partly advanced, then load+step: load wins and clears it.
    apply(0, 8'h00, 0, 1);
    apply(0, 8'h00, 0, 1);
    apply(1, 8'h3C, 1, 1);  chk("load_step", bus.state, 8'h3C);
    repeat (3) apply(0, 8'h00, 0, 1);
    chk("pre_hold", bus.state, 8'h3C);
    apply(0, 8'h00, 0, 1);  chk("pre_tick", bus.state, 8'h9E);

    // step held while run ticks coincide
    repeat (12) apply(0, 8'h00, 1, 1);

    // full cycle from A5 with step and run both high: exactly 255 advances
    apply(1, 8'hA5, 0, 0);
    bus.load = 1'b0; bus.step = 1'b1; bus.run = 1'b1;
    k = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      k++;
      if (bus.wrap) break;
    end
    chk("wrap_steps",  k,          255);
    chk("period_step", bus.period, 8'd255);
    chk("seed_back",   bus.state,  8'hA5);
    apply(0, 8'h00, 0, 0);
    chk("wrap_pulse", bus.wrap, 1'b0);

    // auto-run from reset: one advance per DIV cycles, 255 advances to wrap
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.run = 1'b1;
    k = 0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      k++;
      if (bus.wrap) break;
    end
    chk("run_cycles", k,          1020);
    chk("run_period", bus.period, 8'd255);

    // asynchronous reset between edges while running
    repeat (6) apply(0, 8'h00, 0, 1);
    chk("pre_async_state", bus.state, 8'h80);
    #2 reset = 1'b1;
    #1;
    chk("async_state", bus.state, 8'h01);
    chk("async_wrap",  bus.wrap,  1'b0);
    chk("async_hex",   bus.hex,   14'b1000000_1111001);
    @(negedge clk);
    reset = 1'b0;
    k = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      k++;
      if (bus.state != 8'h01) break;
    end
    chk("first_adv_after_rst", k, 4);

    apply(0, 8'h00, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
